// File: rtl/axi_rd_slave_model.sv
// AXI4 read-only slave endpoint: one burst at a time, per-beat FIXED/INCR/WRAP addressing,
// returns address XOR PATTERN as data and flags illegal bursts (SLVERR) or out-of-window beats (DECERR).
module axi_rd_slave_model #(
    parameter int                ADDR_W    = 32,
    parameter int                LEN_W     = 8,
    parameter int                SIZE_W    = 3,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                WIN_BYTES = 1024,
    parameter logic [31:0]       PATTERN   = 32'hA5A5_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] araddr,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [SIZE_W-1:0] arsize,
    input  logic [1:0]        arburst,
    input  logic              arvalid,
    output logic              arready,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast
);

    localparam int                DBYTES    = DATA_W / 8;
    localparam logic [SIZE_W-1:0] MAX_SIZE  = SIZE_W'($clog2(DBYTES));
    localparam logic [ADDR_W-1:0] WIN_SIZE  = ADDR_W'(WIN_BYTES);
    localparam logic [ADDR_W-1:0] DATA_MASK = ~(ADDR_W'(DBYTES - 1));
    localparam logic [DATA_W-1:0] PAT       = DATA_W'(PATTERN);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  beat_reg;
    logic [SIZE_W-1:0] size_reg;
    logic [1:0]        burst_reg;
    logic              err_reg;
    logic              arready_reg;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;
    logic              rlast_reg;

    logic [ADDR_W-1:0] beat_bytes;
    logic [ADDR_W-1:0] incr_addr;
    logic [ADDR_W-1:0] wrap_span;
    logic [ADDR_W-1:0] wrap_lower;
    logic [ADDR_W-1:0] wrap_step;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] ar_size_mask;
    logic              ar_err;
    logic              ar_wrap_len_ok;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_err;
    logic              sel_last;
    logic              sel_in_win;
    logic [DATA_W-1:0] rdata_next;
    logic [1:0]        rresp_next;

    // Address of the beat that follows the one currently presented.
    always_comb begin
        beat_bytes = ADDR_W'(1) << size_reg;
        incr_addr  = (addr_reg & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
        wrap_span  = (ADDR_W'(len_reg) + ADDR_W'(1)) << size_reg;
        wrap_lower = addr_reg & ~(wrap_span - ADDR_W'(1));
        wrap_step  = addr_reg + beat_bytes;
        if (wrap_step == wrap_lower + wrap_span) begin
            wrap_step = wrap_lower;
        end
        case (burst_reg)
            BURST_INCR: addr_next = incr_addr;
            BURST_WRAP: addr_next = wrap_step;
            default:    addr_next = addr_reg;
        endcase
    end

    // Burst-level legality, judged once on the incoming AR.
    always_comb begin
        ar_size_mask   = (ADDR_W'(1) << arsize) - ADDR_W'(1);
        ar_wrap_len_ok = (arlen == LEN_W'(1)) || (arlen == LEN_W'(3)) ||
                         (arlen == LEN_W'(7)) || (arlen == LEN_W'(15));
        ar_err = (arsize > MAX_SIZE) || (arburst == BURST_RSVD) ||
                 ((arburst == BURST_WRAP) && !ar_wrap_len_ok) ||
                 ((arburst == BURST_WRAP) && ((araddr & ar_size_mask) != '0));
    end

    // In IDLE the next beat is beat 0 of the arriving burst; in BURST it is the following beat.
    always_comb begin
        if (state_reg == IDLE) begin
            sel_addr = araddr;
            sel_err  = ar_err;
            sel_last = (arlen == '0);
        end else begin
            sel_addr = addr_next;
            sel_err  = err_reg;
            sel_last = ((beat_reg + LEN_W'(1)) == len_reg);
        end
        sel_in_win = ((sel_addr - BASE_ADDR) < WIN_SIZE);
        rdata_next = '0;
        rresp_next = RESP_OKAY;
        if (sel_err) begin
            rresp_next = RESP_SLVERR;
        end else if (!sel_in_win) begin
            rresp_next = RESP_DECERR;
        end else begin
            rdata_next = DATA_W'(sel_addr & DATA_MASK) ^ PAT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            addr_reg    <= '0;
            len_reg     <= '0;
            beat_reg    <= '0;
            size_reg    <= '0;
            burst_reg   <= BURST_FIXED;
            err_reg     <= 1'b0;
            arready_reg <= 1'b0;
            rvalid_reg  <= 1'b0;
            rdata_reg   <= '0;
            rresp_reg   <= RESP_OKAY;
            rlast_reg   <= 1'b0;
        end else if (state_reg == IDLE) begin
            arready_reg <= 1'b1;
            if (arvalid && arready_reg) begin
                state_reg   <= BURST;
                addr_reg    <= araddr;
                len_reg     <= arlen;
                size_reg    <= arsize;
                burst_reg   <= arburst;
                beat_reg    <= '0;
                err_reg     <= ar_err;
                arready_reg <= 1'b0;
                rvalid_reg  <= 1'b1;
                rdata_reg   <= rdata_next;
                rresp_reg   <= rresp_next;
                rlast_reg   <= sel_last;
            end
        end else if (rready) begin
            if (rlast_reg) begin
                state_reg   <= IDLE;
                arready_reg <= 1'b1;
                rvalid_reg  <= 1'b0;
                rdata_reg   <= '0;
                rresp_reg   <= RESP_OKAY;
                rlast_reg   <= 1'b0;
            end else begin
                beat_reg  <= beat_reg + LEN_W'(1);
                addr_reg  <= addr_next;
                rdata_reg <= rdata_next;
                rresp_reg <= rresp_next;
                rlast_reg <= sel_last;
            end
        end
    end

    assign arready = arready_reg;
    assign rvalid  = rvalid_reg;
    assign rdata   = rdata_reg;
    assign rresp   = rresp_reg;
    assign rlast   = rlast_reg;

endmodule

// File: tb/tb_axi_rd_slave_model.sv
// Scoreboard bench for axi_rd_slave_model: expected beats are queued when an AR is issued
// and compared as each R handshake is observed.
module tb_axi_rd_slave_model;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    axi_rd_slave_model #(
        .ADDR_W   (32),
        .LEN_W    (8),
        .SIZE_W   (3),
        .DATA_W   (32),
        .BASE_ADDR(32'h0000_0000),
        .WIN_BYTES(1024),
        .PATTERN  (32'hA5A5_0000)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .araddr (araddr),
        .arlen  (arlen),
        .arsize (arsize),
        .arburst(arburst),
        .arvalid(arvalid),
        .arready(arready),
        .rvalid (rvalid),
        .rready (rready),
        .rdata  (rdata),
        .rresp  (rresp),
        .rlast  (rlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic push_exp(input logic [31:0] d, input logic [1:0] r, input logic l);
        exp_t e;
        e.data = d;
        e.resp = r;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // Inputs only change at posedge+1, so a negedge sample with rvalid&&rready is a handshake.
    always @(negedge clk) begin
        if (reset_n && rvalid && rready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rdata", rdata, e.data);
                check("rresp", rresp, e.resp);
                check("rlast", rlast, e.last);
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the AR handshake edge.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b);
        bit done;
        done    = 1'b0;
        araddr  = a;
        arlen   = l;
        arsize  = s;
        arburst = b;
        arvalid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (arready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        arvalid = 1'b0;
        if (!done) begin
            check("ar_timeout", 64'd0, 64'd1);
        end else begin
            check("ar2r_latency_rvalid", rvalid, 1'b1);
            check("arready_busy", arready, 1'b0);
        end
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            check({tag, "_drain_timeout"}, exp_q.size(), 0);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check({tag, "_idle_arready"}, arready, 1'b1);
        check({tag, "_idle_rvalid"}, rvalid, 1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        araddr  = '0;
        arlen   = '0;
        arsize  = '0;
        arburst = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_arready", arready, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_rlast", rlast, 1'b0);
        check("rst_rresp", rresp, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_arready", arready, 1'b1);

        // INCR from 0x10, four words
        push_exp(32'hA5A5_0010, 2'b00, 1'b0);
        push_exp(32'hA5A5_0014, 2'b00, 1'b0);
        push_exp(32'hA5A5_0018, 2'b00, 1'b0);
        push_exp(32'hA5A5_001C, 2'b00, 1'b1);
        send_ar(32'h10, 8'd3, 3'd2, 2'b01);
        wait_drain("incr");

        // WRAP 4 x 4 bytes starting at 0x38 wraps inside 0x30..0x3F
        push_exp(32'hA5A5_0038, 2'b00, 1'b0);
        push_exp(32'hA5A5_003C, 2'b00, 1'b0);
        push_exp(32'hA5A5_0030, 2'b00, 1'b0);
        push_exp(32'hA5A5_0034, 2'b00, 1'b1);
        send_ar(32'h38, 8'd3, 3'd2, 2'b10);
        wait_drain("wrap");

        // FIXED halfword at 0x22: data uses the word-aligned address
        push_exp(32'hA5A5_0020, 2'b00, 1'b0);
        push_exp(32'hA5A5_0020, 2'b00, 1'b0);
        push_exp(32'hA5A5_0020, 2'b00, 1'b1);
        send_ar(32'h22, 8'd2, 3'd1, 2'b00);
        wait_drain("fixed");

        // Backpressure on beat 2 for three cycles
        push_exp(32'hA5A5_0010, 2'b00, 1'b0);
        push_exp(32'hA5A5_0014, 2'b00, 1'b0);
        push_exp(32'hA5A5_0018, 2'b00, 1'b0);
        push_exp(32'hA5A5_001C, 2'b00, 1'b1);
        send_ar(32'h10, 8'd3, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        rready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_rvalid", rvalid, 1'b1);
            check("bp_rdata", rdata, 32'hA5A5_0014);
            check("bp_rlast", rlast, 1'b0);
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
        wait_drain("bp");

        // Last word of the window is OKAY, the next one decodes outside
        push_exp(32'hA5A5_03FC, 2'b00, 1'b0);
        push_exp(32'h0000_0000, 2'b11, 1'b1);
        send_ar(32'h3FC, 8'd1, 3'd2, 2'b01);
        wait_drain("decerr");

        // arsize wider than the data bus
        push_exp(32'h0, 2'b10, 1'b0);
        push_exp(32'h0, 2'b10, 1'b1);
        send_ar(32'h0, 8'd1, 3'd3, 2'b01);
        wait_drain("bigsize");

        // WRAP with illegal length
        push_exp(32'h0, 2'b10, 1'b0);
        push_exp(32'h0, 2'b10, 1'b0);
        push_exp(32'h0, 2'b10, 1'b1);
        send_ar(32'h0, 8'd2, 3'd2, 2'b10);
        wait_drain("wraplen");

        // WRAP with unaligned start
        push_exp(32'h0, 2'b10, 1'b0);
        push_exp(32'h0, 2'b10, 1'b1);
        send_ar(32'h3A, 8'd1, 3'd2, 2'b10);
        wait_drain("wrapalign");

        // Reserved burst type
        push_exp(32'h0, 2'b10, 1'b1);
        send_ar(32'h40, 8'd0, 3'd2, 2'b11);
        wait_drain("rsvd");

        // Reset during beat 2 of an 8-beat INCR
        push_exp(32'hA5A5_0000, 2'b00, 1'b0);
        send_ar(32'h0, 8'd7, 3'd2, 2'b01);
        @(posedge clk);
        #1;
        rready = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rvalid", rvalid, 1'b0);
        check("midrst_rlast", rlast, 1'b0);
        check("midrst_beats_left", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rready  = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_arready", arready, 1'b1);
        push_exp(32'hA5A5_0000, 2'b00, 1'b1);
        send_ar(32'h0, 8'd0, 3'd2, 2'b01);
        wait_drain("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_slave_model.md
Name: axi_rd_slave_model

Overview:
- Synthesizable AXI4 read-only slave endpoint (AR and R channels only) that sits directly downstream of an interconnect master port.
- It accepts one read burst at a time and generates each beat's address (FIXED/INCR/WRAP).
- It returns deterministic pattern data, so the interconnect benches can check routing, ordering and burst handling without a memory array.
- It flags illegal or out-of-window accesses with an error response.

Parameters:
ADDR_W, 32, address width
LEN_W, 8, arlen width
SIZE_W, 3, arsize width
DATA_W, 32, data width; power of 2, minimum 8
BASE_ADDR, 32'h0000_0000, first byte address of this slave's window
WIN_BYTES, 1024, window size in bytes; power of 2
PATTERN, 32'hA5A5_0000, XOR pattern applied to data (zero-extended or truncated to DATA_W)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
araddr  in  ADDR_W  read address
arlen  in  LEN_W  beats minus 1
arsize  in  SIZE_W  log2 of bytes per beat
arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
arvalid  in  1  address valid
arready  out  1  address ready
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  read data
rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
rlast  out  1  last beat of burst

Behaviour:
- Reset (async assert, sync deassert): arready=0, rvalid=0, rlast=0, rresp=0, rdata=0; FSM goes to IDLE.
  - arready rises to 1 in the first clk after reset_n deasserts.
- FSM states:
  - IDLE: arready=1, rvalid=0. When arvalid&&arready, latch araddr, arlen, arsize, arburst; clear the beat counter; go to BURST. arready=0 and rvalid=1 from the next cycle, so AR-to-first-R latency is 1 cycle.
  - BURST: arready=0, rvalid=1. When rvalid&&rready, advance the beat.
    - If that beat had rlast=1, go to IDLE; next cycle rvalid=0 and arready=1.
    - Only one burst is outstanding; there are no back-to-back AR accepts during BURST.
- R stability: while rvalid&&!rready, rdata, rresp and rlast are held constant.
- rlast: asserted exactly when beat counter == latched arlen.
- Beat address, with bytes = 1<<arsize:
  - FIXED: every beat uses araddr.
  - INCR: beat0 = araddr (may be unaligned); each later beat = previous address aligned down to bytes, plus bytes. Arithmetic is ADDR_W wide and wraps modulo 2^ADDR_W.
  - WRAP: span = (arlen+1)*bytes; lower = araddr aligned down to span. Each next address = previous + bytes; if that reaches lower+span, it returns to lower.
- Per-beat response, highest priority first:
  - Burst-level SLVERR applies to every beat of the burst, with rdata=0, if any of:
    - arsize > log2(DATA_W/8)
    - arburst==11
    - WRAP with arlen not in {1,3,7,15}
    - WRAP with araddr not aligned to bytes
  - Otherwise, a beat address outside [BASE_ADDR, BASE_ADDR+WIN_BYTES) gives DECERR with rdata=0, for that beat only.
  - Otherwise: rresp=OKAY, rdata = (beat address aligned down to DATA_W/8) XOR PATTERN.
- Burst length is always honoured: an errored burst still returns arlen+1 beats with correct rlast.
- AR handshake ignores araddr range; decode errors appear only on R.
- reset_n asserted mid-burst:
  - rvalid and rlast drop immediately (asynchronously).
  - The burst is abandoned; after deassertion the block is in IDLE with arready=1.
- arvalid during BURST is left pending; it is accepted on the first IDLE cycle.

Test Plan:
All scenarios use DATA_W=32, BASE_ADDR=0, WIN_BYTES=1024, PATTERN=32'hA5A5_0000.
1. INCR burst: AR addr=0x10, len=3, size=2, burst=01, rready=1 -> rvalid one cycle after the AR handshake; beats 0xA5A50010, 0xA5A50014, 0xA5A50018, 0xA5A5001C; rresp=00; rlast only on beat 4; arready=1 the cycle after the last handshake.
2. WRAP burst: AR addr=0x38, len=3, size=2, burst=10 -> beat addresses 0x38, 0x3C, 0x30, 0x34; data 0xA5A50038, 0xA5A5003C, 0xA5A50030, 0xA5A50034.
3. FIXED burst: AR addr=0x22, len=2, size=1, burst=00 -> 3 beats each 0xA5A50020; rresp=00; rlast on beat 3.
4. Backpressure: scenario 1 with rready low for 3 cycles on beat 2 -> rdata=0xA5A50014 and rlast=0 held stable for all 3 cycles; no beat dropped or repeated.
5. Errors:
   - INCR addr=0x3FC, len=1, size=2 -> beat1 0xA5A503FC OKAY; beat2 rdata=0, rresp=11, rlast=1.
   - arsize=3, len=1 -> 2 beats of rresp=10, rdata=0.
   - WRAP len=2 -> 3 beats of rresp=10, rdata=0.
6. Reset mid-burst: assert reset_n=0 during beat 2 of an INCR len=7 burst -> rvalid=0 immediately. After release, arready=1; a new AR addr=0x0, len=0 returns a single beat 0xA5A50000 with rlast=1.
